// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, opcode encodings,
// FSM state encodings and access-size helpers.
package mem_stage_pkg;

    localparam int REG_W      = 32;  // register data bus
    localparam int REG_ADDR_W = 5;   // register index bus
    localparam int OP_W       = 8;   // opcode bus

    // Opcode encodings; anything not listed below is a non-memory op.
    localparam logic [OP_W-1:0] OP_NOP = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD = 8'h01;
    localparam logic [OP_W-1:0] OP_LB  = 8'h20;
    localparam logic [OP_W-1:0] OP_LH  = 8'h21;
    localparam logic [OP_W-1:0] OP_LW  = 8'h22;
    localparam logic [OP_W-1:0] OP_LBU = 8'h24;
    localparam logic [OP_W-1:0] OP_LHU = 8'h25;
    localparam logic [OP_W-1:0] OP_SB  = 8'h28;
    localparam logic [OP_W-1:0] OP_SH  = 8'h29;
    localparam logic [OP_W-1:0] OP_SW  = 8'h2a;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACCESS    = 2'd1;
    localparam logic [1:0] ST_WAIT_LAST = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Number of bytes moved by an access; 0 for non-memory ops.
    function automatic logic [2:0] op_bytes(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

    // Halfwords need a 2-byte aligned address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
        return ((op_bytes(op) == 3'd2) && a[0]) ||
               ((op_bytes(op) == 3'd4) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extender: assembled little-endian load bytes + opcode -> write-back data.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [REG_W-1:0] raw_data,
    input  logic [OP_W-1:0]  op,
    output logic [REG_W-1:0] ext_data
);

    // Sign-extend LB/LH, zero-extend LBU/LHU, pass LW through.
    always_comb begin
        ext_data = raw_data;
        case (op)
            OP_LB:   ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
            OP_LBU:  ext_data = {24'h0, raw_data[7:0]};
            OP_LH:   ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
            OP_LHU:  ext_data = {16'h0, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Loads/stores are carried out one byte per granted
// request on a byte-wide RAM port while the pipe is stalled.
// Optional macro MEM_MISALIGN_CHK_EN: reject misaligned halfword/word
// accesses and report them on misalign_o.
//
// RAM handshake: while mem_req_o is high, mem_addr_o/mem_we_o/mem_dout_o
// stay stable until a cycle in which mem_gnt_i is high; the clock edge
// ending that cycle completes the byte. For a granted read, mem_din_i
// carries the byte during the following cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [OP_W-1:0]       opcode_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  stallreq_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [7:0]            mem_dout_o,
    input  logic [7:0]            mem_din_i,
    input  logic                  mem_gnt_i,
`ifdef MEM_MISALIGN_CHK_EN
    output logic                  misalign_o,
`endif
    output logic [1:0]            dbg_state_o
);

    logic [1:0]        state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [OP_W-1:0]   op_q;
    logic [REG_W-1:0]  data_q;
    logic              pend_q;      // a granted read byte arrives this cycle
    logic [1:0]        pend_idx_q;  // which byte lane it belongs to
    logic              reject;
    logic [REG_W-1:0]  ext_data;

    assign cnt_nxt     = cnt_q + 3'd1;
    assign dbg_state_o = rst ? state_q : ST_IDLE;

`ifdef MEM_MISALIGN_CHK_EN
    logic misal_q;
    assign reject     = misaligned(opcode_i, mem_addr_i[1:0]);
    assign misalign_o = rst && (state_q == ST_DONE) && misal_q;

    // Remember a rejected access so DONE can flag it and suppress write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misal_q <= 1'b0;
        else if (state_q == ST_IDLE)
            misal_q <= is_mem(opcode_i) && reject;
        else if (state_q == ST_DONE)
            misal_q <= 1'b0;
    end
`else
    assign reject = 1'b0;
`endif

    mem_load_ext u_load_ext (
        .raw_data (data_q),
        .op       (op_q),
        .ext_data (ext_data)
    );

    // Access FSM, byte counter and read-data assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            base_q     <= '0;
            op_q       <= OP_NOP;
            data_q     <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
        end else begin
            pend_q <= 1'b0;
            if (pend_q)
                data_q[{pend_idx_q, 3'b000} +: 8] <= mem_din_i;
            case (state_q)
                ST_IDLE: begin
                    if (is_mem(opcode_i)) begin
                        base_q  <= mem_addr_i;
                        op_q    <= opcode_i;
                        data_q  <= '0;
                        cnt_q   <= 3'd0;
                        state_q <= reject ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_gnt_i) begin
                        cnt_q <= cnt_nxt;
                        if (!is_store(op_q)) begin
                            pend_q     <= 1'b1;
                            pend_idx_q <= cnt_q[1:0];
                        end
                        if (cnt_nxt == op_bytes(op_q))
                            state_q <= is_store(op_q) ? ST_DONE : ST_WAIT_LAST;
                    end
                end
                ST_WAIT_LAST: state_q <= ST_DONE;
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Output decode by state; everything forced low while reset is asserted.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_dout_o = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (is_mem(opcode_i)) begin
                    stallreq_o = 1'b1;
                end else begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
            end
            ST_ACCESS: begin
                stallreq_o = 1'b1;
                mem_req_o  = 1'b1;
                mem_we_o   = is_store(op_q);
                mem_addr_o = base_q + ADDR_W'(cnt_q);
                mem_dout_o = wdata_i[{cnt_q[1:0], 3'b000} +: 8];
            end
            ST_WAIT_LAST: stallreq_o = 1'b1;
            default: begin
                wd_o    = wd_i;
                wdata_o = ext_data;
`ifdef MEM_MISALIGN_CHK_EN
                wreg_o  = wreg_i && is_load(op_q) && !misal_q;
`else
                wreg_o  = wreg_i && is_load(op_q);
`endif
            end
        endcase
        if (!rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            stallreq_o = 1'b0;
            mem_req_o  = 1'b0;
            mem_we_o   = 1'b0;
            mem_addr_o = '0;
            mem_dout_o = 8'h00;
        end
    end

endmodule
